// File: rtl/hazard_ctrl_unit_if.sv
// Hazard controller bundle: DECODE/EX/MEM hazard inputs from the core and
// the pipeline enables/flush/mux controls returned to it.
interface hazard_ctrl_unit_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_load;
    logic              branch_taken;
    logic              dmem_req;
    logic              dmem_ready;
    logic              cnt_clr;
    logic              pc_en;
    logic              ifid_en;
    logic              ifid_flush;
    logic              idex_en;
    logic              exmem_en;
    logic              ctrl_sel;
    logic [CNT_W-1:0]  stall_cycles;

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_load,
               branch_taken, dmem_req, dmem_ready, cnt_clr,
        input  pc_en, ifid_en, ifid_flush, idex_en, exmem_en, ctrl_sel,
               stall_cycles
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_load,
               branch_taken, dmem_req, dmem_ready, cnt_clr,
        output pc_en, ifid_en, ifid_flush, idex_en, exmem_en, ctrl_sel,
               stall_cycles
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Pipeline hazard controller: load-use bubbles, data-memory freeze,
// taken-branch flush and a saturating stall-cycle counter.
//
// state    | meaning
// RUN      | normal issue; a load-use hit stalls PC/IF-ID for the first bubble
// LU_STALL | remaining load-use bubbles, counted down in bub_cnt_q
module hazard_ctrl_unit #(
    parameter int REG_AW     = 5,
    parameter int LU_BUBBLES = 1,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    hazard_ctrl_unit_if.slave  hz
);
    typedef enum logic {RUN, LU_STALL} state_t;

    localparam logic [1:0]       BUB_LOAD = 2'(LU_BUBBLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state_q, state_d;
    logic [1:0]       bub_cnt_q, bub_cnt_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    logic lu_hit, freeze;
    logic pc_en, ifid_en, ifid_flush, idex_en, exmem_en, ctrl_sel;

    always_comb begin
        freeze = hz.dmem_req & ~hz.dmem_ready;
        lu_hit = hz.ex_load & (hz.ex_rd != REG_AW'(0)) &
                 ((hz.id_rs1_used & (hz.id_rs1 == hz.ex_rd)) |
                  (hz.id_rs2_used & (hz.id_rs2 == hz.ex_rd)));

        state_d    = state_q;
        bub_cnt_d  = bub_cnt_q;
        pc_en      = 1'b1;
        ifid_en    = 1'b1;
        idex_en    = 1'b1;
        exmem_en   = 1'b1;
        ifid_flush = 1'b0;
        ctrl_sel   = 1'b1;

        // A frozen cycle holds everything, including a pending branch in EX.
        if (freeze) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
        end else if (hz.branch_taken) begin
            ifid_flush = 1'b1;
            ctrl_sel   = 1'b0;
            state_d    = RUN;
            bub_cnt_d  = 2'd0;
        end else if (state_q == LU_STALL) begin
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            ctrl_sel  = 1'b0;
            bub_cnt_d = bub_cnt_q - 2'd1;
            if (bub_cnt_q == 2'd1) state_d = RUN;
        end else if (lu_hit) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            ctrl_sel = 1'b0;
            if (LU_BUBBLES > 1) begin
                state_d   = LU_STALL;
                bub_cnt_d = BUB_LOAD;
            end
        end

        stall_cycles_d = stall_cycles_q;
        if (hz.cnt_clr)
            stall_cycles_d = '0;
        else if (!pc_en && stall_cycles_q != CNT_MAX)
            stall_cycles_d = stall_cycles_q + CNT_W'(1);

        // Reset must quiesce the pipeline without waiting for a clock edge.
        if (!rst_n) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_en    = 1'b0;
            exmem_en   = 1'b0;
            ifid_flush = 1'b1;
            ctrl_sel   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= RUN;
            bub_cnt_q      <= 2'd0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            bub_cnt_q      <= bub_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign hz.pc_en        = pc_en;
    assign hz.ifid_en      = ifid_en;
    assign hz.ifid_flush   = ifid_flush;
    assign hz.idex_en      = idex_en;
    assign hz.exmem_en     = exmem_en;
    assign hz.ctrl_sel     = ctrl_sel;
    assign hz.stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: one instance with a single bubble,
// one with three bubbles and a 4-bit counter.
module tb_hazard_ctrl_unit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_unit_if #(.REG_AW(5), .CNT_W(16)) if1 ();
    hazard_ctrl_unit_if #(.REG_AW(5), .CNT_W(4))  if3 ();

    hazard_ctrl_unit #(.REG_AW(5), .LU_BUBBLES(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .hz(if1.slave));
    hazard_ctrl_unit #(.REG_AW(5), .LU_BUBBLES(3), .CNT_W(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .hz(if3.slave));

    // {pc_en, ifid_en, ifid_flush, idex_en, exmem_en, ctrl_sel}
    localparam logic [5:0] O_RUN = 6'b110111;
    localparam logic [5:0] O_STL = 6'b000110;
    localparam logic [5:0] O_FRZ = 6'b000001;
    localparam logic [5:0] O_BR  = 6'b111110;
    localparam logic [5:0] O_RST = 6'b001000;

    typedef struct {
        string       name;
        bit          sel;
        logic [5:0]  eo;
        logic [15:0] ec;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            logic [5:0]  ao;
            logic [15:0] ac;
            e = sb.pop_front();
            if (e.sel) begin
                ao = {if3.pc_en, if3.ifid_en, if3.ifid_flush, if3.idex_en, if3.exmem_en, if3.ctrl_sel};
                ac = {12'd0, if3.stall_cycles};
            end else begin
                ao = {if1.pc_en, if1.ifid_en, if1.ifid_flush, if1.idex_en, if1.exmem_en, if1.ctrl_sel};
                ac = if1.stall_cycles;
            end
            vectors++;
            if (ao !== e.eo || ac !== e.ec) begin
                miscompares++;
                $display("FAIL %s (dut%0d): outs=%b cnt=%0d, expected outs=%b cnt=%0d",
                         e.name, e.sel ? 3 : 1, ao, ac, e.eo, e.ec);
            end
        end
    end

    task automatic zero_inputs();
        if1.id_rs1 = '0; if1.id_rs2 = '0; if1.id_rs1_used = 0; if1.id_rs2_used = 0;
        if1.ex_rd = '0; if1.ex_load = 0; if1.branch_taken = 0; if1.dmem_req = 0;
        if1.dmem_ready = 0; if1.cnt_clr = 0;
        if3.id_rs1 = '0; if3.id_rs2 = '0; if3.id_rs1_used = 0; if3.id_rs2_used = 0;
        if3.ex_rd = '0; if3.ex_load = 0; if3.branch_taken = 0; if3.dmem_req = 0;
        if3.dmem_ready = 0; if3.cnt_clr = 0;
    endtask

    task automatic drive(input string nm, input bit sel, input logic r,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd,
                         input logic ld, input logic br, input logic rq,
                         input logic rdy, input logic clr,
                         input logic [5:0] eo, input logic [15:0] ec);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n = r;
        zero_inputs();
        if (sel) begin
            if3.id_rs1 = rs1; if3.id_rs2 = rs2; if3.id_rs1_used = u1; if3.id_rs2_used = u2;
            if3.ex_rd = rd; if3.ex_load = ld; if3.branch_taken = br; if3.dmem_req = rq;
            if3.dmem_ready = rdy; if3.cnt_clr = clr;
        end else begin
            if1.id_rs1 = rs1; if1.id_rs2 = rs2; if1.id_rs1_used = u1; if1.id_rs2_used = u2;
            if1.ex_rd = rd; if1.ex_load = ld; if1.branch_taken = br; if1.dmem_req = rq;
            if1.dmem_ready = rdy; if1.cnt_clr = clr;
        end
        e.name = nm; e.sel = sel; e.eo = eo; e.ec = ec;
        sb.push_back(e);
    endtask

    task automatic idle(input string nm, input bit sel, input logic [5:0] eo, input logic [15:0] ec);
        drive(nm, sel, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, eo, ec);
    endtask

    task automatic clr(input string nm, input bit sel, input logic [5:0] eo, input logic [15:0] ec);
        drive(nm, sel, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, eo, ec);
    endtask

    task automatic frz(input string nm, input bit sel, input logic br, input logic [5:0] eo, input logic [15:0] ec);
        drive(nm, sel, 1, 0, 0, 0, 0, 0, 0, br, 1, 0, 0, eo, ec);
    endtask

    initial begin
        zero_inputs();
        // reset state of both instances
        drive("rst1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST, 0);
        drive("rst3", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST, 0);
        idle("run1", 0, O_RUN, 0);

        // single-bubble instance
        drive("lu1_rs1", 0, 1, 5, 0, 1, 0, 5, 1, 0, 0, 0, 0, O_STL, 0);
        idle("lu1_after", 0, O_RUN, 1);
        drive("x0", 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, O_RUN, 1);
        drive("rs2_unused", 0, 1, 0, 7, 0, 0, 7, 1, 0, 0, 0, 0, O_RUN, 1);
        drive("rs1_unused", 0, 1, 7, 0, 0, 1, 7, 1, 0, 0, 0, 0, O_RUN, 1);
        drive("no_load", 0, 1, 7, 7, 1, 1, 7, 0, 0, 0, 0, 0, O_RUN, 1);
        drive("lu1_rs2", 0, 1, 0, 7, 0, 1, 7, 1, 0, 0, 0, 0, O_STL, 1);
        idle("lu1_rs2_after", 0, O_RUN, 2);
        frz("frz1", 0, 0, O_FRZ, 2);
        drive("frz1_done", 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, O_RUN, 3);
        drive("br_over_lu", 0, 1, 5, 0, 1, 0, 5, 1, 1, 0, 0, 0, O_BR, 3);
        idle("br_over_lu_after", 0, O_RUN, 3);

        // three-bubble instance
        drive("lu3_b1", 1, 1, 0, 12, 0, 1, 12, 1, 0, 0, 0, 0, O_STL, 0);
        idle("lu3_b2", 1, O_STL, 1);
        idle("lu3_b3", 1, O_STL, 2);
        idle("lu3_run", 1, O_RUN, 3);
        clr("clr_a", 1, O_RUN, 3);
        idle("clr_a_done", 1, O_RUN, 0);

        drive("lf_b1", 1, 1, 0, 12, 0, 1, 12, 1, 0, 0, 0, 0, O_STL, 0);
        frz("lf_frz1", 1, 0, O_FRZ, 1);
        frz("lf_frz2", 1, 0, O_FRZ, 2);
        idle("lf_b2", 1, O_STL, 3);
        idle("lf_b3", 1, O_STL, 4);
        idle("lf_run", 1, O_RUN, 5);
        clr("clr_b", 1, O_RUN, 5);
        idle("clr_b_done", 1, O_RUN, 0);

        drive("lb_b1", 1, 1, 9, 0, 1, 0, 9, 1, 0, 0, 0, 0, O_STL, 0);
        drive("lb_br", 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, O_BR, 1);
        idle("lb_run1", 1, O_RUN, 1);
        idle("lb_run2", 1, O_RUN, 1);
        frz("br_frozen", 1, 1, O_FRZ, 1);
        drive("br_released", 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, O_BR, 2);

        for (int k = 0; k < 20; k++)
            frz("sat", 1, 0, O_FRZ, (k + 2 > 15) ? 16'd15 : 16'(k + 2));
        idle("sat_hold", 1, O_RUN, 15);
        clr("clr_c", 1, O_RUN, 15);
        idle("clr_c_done", 1, O_RUN, 0);

        drive("rst_mid_b1", 1, 1, 0, 12, 0, 1, 12, 1, 0, 0, 0, 0, O_STL, 0);
        drive("rst_mid", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST, 0);
        drive("rst_mid_hold", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, O_RST, 0);
        idle("rst_release", 1, O_RUN, 0);
        drive("post_rst_b1", 1, 1, 0, 12, 0, 1, 12, 1, 0, 0, 0, 0, O_STL, 0);
        idle("post_rst_b2", 1, O_STL, 1);
        idle("post_rst_b3", 1, O_STL, 2);
        idle("post_rst_run", 1, O_RUN, 3);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
